// File: rtl/game_core_multi.sv
// Multi-obstacle game core: collisions, pass-once scoring, lives, invulnerability, high score.
// Latency: 1 cycle; outputs are registered and evaluated only on tick (start/restart/reset act immediately).
// Backpressure: none; the frame tick is a free-running strobe and every tick is consumed.
module game_core_multi #(
    parameter int X_W          = 8,
    parameter int Y_W          = 8,
    parameter int N_OBS        = 4,
    parameter int SCORE_W      = 16,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   restart,
    input  logic [N_OBS*X_W-1:0]   obs_x,
    input  logic [N_OBS*Y_W-1:0]   obs_y,
    input  logic [N_OBS-1:0]       obs_valid,
    input  logic [X_W-1:0]         player_x,
    input  logic [Y_W-1:0]         player_y,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     high_score,
    output logic [2:0]             lives,
    output logic [1:0]             state,
    output logic                   game_over,
    output logic                   hit_pulse
);
    localparam int TIMER_W = (INVULN_TICKS < 2) ? 1 : $clog2(INVULN_TICKS + 1);
    localparam int CNT_W   = (N_OBS < 2) ? 1 : $clog2(N_OBS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(INVULN_TICKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        INVULN = 2'd2,
        OVER   = 2'd3
    } gameState_t;

    gameState_t           stateQ, stateD;
    logic [SCORE_W-1:0]   scoreQ, scoreD, highQ, highD;
    logic [2:0]           livesQ, livesD;
    logic [TIMER_W-1:0]   timerQ, timerD;
    logic [N_OBS-1:0]     passedQ, passedD;
    logic                 hitQ, hitD;
    logic                 gameOverQ;

    logic [N_OBS-1:0]     coll, newPass, respawn;
    logic [CNT_W-1:0]     passCount;
    logic [SCORE_W:0]     scoreSum;
    logic [SCORE_W-1:0]   scoreSat;

    always_comb begin
        coll      = '0;
        newPass   = '0;
        respawn   = '0;
        passCount = '0;
        for (int i = 0; i < N_OBS; i++) begin
            coll[i]    = obs_valid[i] && (obs_x[i*X_W +: X_W] == player_x)
                                      && (obs_y[i*Y_W +: Y_W] == player_y);
            newPass[i] = obs_valid[i] && (obs_x[i*X_W +: X_W] < player_x) && !passedQ[i];
            respawn[i] = !obs_valid[i] || (obs_x[i*X_W +: X_W] > player_x);
            passCount  = passCount + CNT_W'(newPass[i]);
        end
    end

    // One extra bit of headroom detects overflow so the score can clamp instead of wrapping.
    assign scoreSum = {1'b0, scoreQ} + (SCORE_W+1)'(passCount);
    assign scoreSat = scoreSum[SCORE_W] ? SCORE_MAX : scoreSum[SCORE_W-1:0];

    always_comb begin
        stateD  = stateQ;
        scoreD  = scoreQ;
        highD   = highQ;
        livesD  = livesQ;
        timerD  = timerQ;
        passedD = passedQ;
        hitD    = 1'b0;
        if (restart) begin
            stateD  = IDLE;
            scoreD  = '0;
            livesD  = LIVES_INIT;
            timerD  = '0;
            passedD = '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (start) stateD = PLAY;
                end
                OVER: begin
                    if (scoreQ > highQ) highD = scoreQ;
                end
                default: begin
                    if (tick) begin
                        scoreD  = scoreSat;
                        passedD = (passedQ & ~respawn) | newPass;
                        if (stateQ == PLAY) begin
                            if (|coll) begin
                                hitD   = 1'b1;
                                livesD = livesQ - 3'd1;
                                if (livesQ <= 3'd1) begin
                                    stateD = OVER;
                                end else begin
                                    stateD = INVULN;
                                    timerD = TIMER_INIT;
                                end
                            end
                        end else if (timerQ <= TIMER_W'(1)) begin
                            // Collisions on the expiring tick are still ignored.
                            timerD = '0;
                            stateD = PLAY;
                        end else begin
                            timerD = timerQ - TIMER_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ    <= IDLE;
            scoreQ    <= '0;
            highQ     <= '0;
            livesQ    <= LIVES_INIT;
            timerQ    <= '0;
            passedQ   <= '0;
            hitQ      <= 1'b0;
            gameOverQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            scoreQ    <= scoreD;
            highQ     <= highD;
            livesQ    <= livesD;
            timerQ    <= timerD;
            passedQ   <= passedD;
            hitQ      <= hitD;
            gameOverQ <= (stateD == OVER);
        end
    end

    assign score      = scoreQ;
    assign high_score = highQ;
    assign lives      = livesQ;
    assign state      = stateQ;
    assign game_over  = gameOverQ;
    assign hit_pulse  = hitQ;
endmodule

// File: tb/tb_game_core_multi.sv
// Bench for game_core_multi: a 16-bit-score and a 4-bit-score instance share stimulus
// and are checked against a frame-level game model plus directed expectations.
module tb_game_core_multi;
    logic        clock = 1'b0;
    logic        reset = 1'b1, tick = 1'b0, start = 1'b0, restart = 1'b0;
    logic [31:0] obs_x = '0, obs_y = '0;
    logic [3:0]  obs_valid = '0;
    logic [7:0]  player_x = 8'd10, player_y = 8'd10;

    logic [15:0] scoreA, highA;
    logic [3:0]  scoreB, highB;
    logic [2:0]  livesA, livesB;
    logic [1:0]  stateA, stateB;
    logic        goA, goB, hitA, hitB;

    int vectors = 0;
    int miscompares = 0;

    // Model state per instance (0: SCORE_W=16, 1: SCORE_W=4); states 0 idle,1 play,2 invuln,3 over.
    int mSc[2], mHs[2], mLv[2], mSt[2], mTm[2];
    bit mHit[2];
    bit mPass[2][4];
    int mMax[2] = '{65535, 15};

    always #5 clock = ~clock;

    game_core_multi #(.X_W(8), .Y_W(8), .N_OBS(4), .SCORE_W(16), .LIVES(3), .INVULN_TICKS(2)) dutA (
        .clock(clock), .reset(reset), .tick(tick), .start(start), .restart(restart),
        .obs_x(obs_x), .obs_y(obs_y), .obs_valid(obs_valid),
        .player_x(player_x), .player_y(player_y),
        .score(scoreA), .high_score(highA), .lives(livesA), .state(stateA),
        .game_over(goA), .hit_pulse(hitA));

    game_core_multi #(.X_W(8), .Y_W(8), .N_OBS(4), .SCORE_W(4), .LIVES(3), .INVULN_TICKS(2)) dutB (
        .clock(clock), .reset(reset), .tick(tick), .start(start), .restart(restart),
        .obs_x(obs_x), .obs_y(obs_y), .obs_valid(obs_valid),
        .player_x(player_x), .player_y(player_y),
        .score(scoreB), .high_score(highB), .lives(livesB), .state(stateB),
        .game_over(goB), .hit_pulse(hitB));

    task automatic model_update();
        int gained;
        bit anyHit;
        int ox, oy;
        for (int k = 0; k < 2; k++) begin
            if (reset || restart) begin
                mSc[k] = 0; mLv[k] = 3; mSt[k] = 0; mTm[k] = 0; mHit[k] = 0;
                if (reset) mHs[k] = 0;
                for (int i = 0; i < 4; i++) mPass[k][i] = 0;
            end else begin
                mHit[k] = 0;
                if (mSt[k] == 0) begin
                    if (start) mSt[k] = 1;
                end else if (mSt[k] == 3) begin
                    if (mSc[k] > mHs[k]) mHs[k] = mSc[k];
                end else if (tick) begin
                    gained = 0;
                    anyHit = 0;
                    for (int i = 0; i < 4; i++) begin
                        ox = int'(obs_x[i*8 +: 8]);
                        oy = int'(obs_y[i*8 +: 8]);
                        if (obs_valid[i] && ox == int'(player_x) && oy == int'(player_y)) anyHit = 1;
                        if (obs_valid[i] && ox < int'(player_x) && !mPass[k][i]) begin
                            gained++;
                            mPass[k][i] = 1;
                        end else if (!obs_valid[i] || ox > int'(player_x)) begin
                            mPass[k][i] = 0;
                        end
                    end
                    mSc[k] = (mSc[k] + gained > mMax[k]) ? mMax[k] : mSc[k] + gained;
                    if (mSt[k] == 1 && anyHit) begin
                        mLv[k]--;
                        mHit[k] = 1;
                        mSt[k] = (mLv[k] == 0) ? 3 : 2;
                        mTm[k] = 2;
                    end else if (mSt[k] == 2) begin
                        mTm[k]--;
                        if (mTm[k] == 0) mSt[k] = 1;
                    end
                end
            end
        end
    endtask

    // Inputs change on the falling edge; the model consumes them on the rising edge.
    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic set_ch(input int i, input bit v, input int x, input int y);
        obs_valid[i]     = v;
        obs_x[i*8 +: 8]  = 8'(x);
        obs_y[i*8 +: 8]  = 8'(y);
    endtask

    task automatic pulse_restart();
        restart = 1'b1; step(); restart = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        vectors++; if (scoreA !== 16'd0) begin miscompares++; $display("FAIL reset_score got=%0d exp=0", scoreA); end
        vectors++; if (highA !== 16'd0) begin miscompares++; $display("FAIL reset_high got=%0d exp=0", highA); end
        vectors++; if (livesA !== 3'd3) begin miscompares++; $display("FAIL reset_lives got=%0d exp=3", livesA); end
        vectors++; if (stateA !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", stateA); end
        vectors++; if ({goA, hitA} !== 2'b00) begin miscompares++; $display("FAIL reset_go_hit got=%b exp=00", {goA, hitA}); end
        vectors++; if ({scoreB, livesB, stateB} !== {4'd0, 3'd3, 2'd0}) begin miscompares++; $display("FAIL reset_b got=%h exp=0c", {scoreB, livesB, stateB}); end
        set_ch(0, 1, 5, 0);
        do_tick();
        vectors++; if ({scoreA, stateA} !== {16'd0, 2'd0}) begin miscompares++; $display("FAIL idle_tick_ignored score=%0d state=%0d exp 0/0", scoreA, stateA); end
    endtask

    task automatic test_start_tick();
        start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
        vectors++; if ({scoreA, stateA} !== {16'd0, 2'd1}) begin miscompares++; $display("FAIL start_tick score=%0d state=%0d exp 0/1", scoreA, stateA); end
        repeat (3) step();
        vectors++; if (scoreA !== 16'd0) begin miscompares++; $display("FAIL no_tick_no_effect score=%0d exp=0", scoreA); end
        pulse_restart();
        vectors++; if (stateA !== 2'd0) begin miscompares++; $display("FAIL restart_from_play state=%0d exp=0", stateA); end
    endtask

    task automatic test_pass_once();
        set_ch(0, 1, 5, 0); set_ch(1, 0, 200, 0); set_ch(2, 1, 5, 0); set_ch(3, 0, 200, 0);
        pulse_start();
        do_tick();
        vectors++; if (scoreA !== 16'd2) begin miscompares++; $display("FAIL pass_two score=%0d exp=2", scoreA); end
        repeat (5) do_tick();
        vectors++; if (scoreA !== 16'd2) begin miscompares++; $display("FAIL pass_once score=%0d exp=2", scoreA); end
        set_ch(0, 1, 20, 0); do_tick();
        set_ch(0, 1, 5, 0); do_tick();
        vectors++; if ({scoreA, hitA} !== {16'd3, 1'b0}) begin miscompares++; $display("FAIL respawn_pass score=%0d hit=%0d exp 3/0", scoreA, hitA); end
    endtask

    task automatic test_collision();
        set_ch(0, 0, 5, 0); set_ch(1, 1, 10, 10); set_ch(2, 0, 5, 0); set_ch(3, 1, 10, 10);
        do_tick();
        vectors++; if ({hitA, livesA, stateA} !== {1'b1, 3'd2, 2'd2}) begin miscompares++; $display("FAIL double_coll hit/lives/state=%0d/%0d/%0d exp 1/2/2", hitA, livesA, stateA); end
        step();
        vectors++; if (hitA !== 1'b0) begin miscompares++; $display("FAIL hit_one_cycle hit=%0d exp=0", hitA); end
        do_tick();
        vectors++; if ({hitA, livesA, stateA} !== {1'b0, 3'd2, 2'd2}) begin miscompares++; $display("FAIL invuln_1 hit/lives/state=%0d/%0d/%0d exp 0/2/2", hitA, livesA, stateA); end
        do_tick();
        vectors++; if ({hitA, livesA, stateA} !== {1'b0, 3'd2, 2'd1}) begin miscompares++; $display("FAIL invuln_end hit/lives/state=%0d/%0d/%0d exp 0/2/1", hitA, livesA, stateA); end
        do_tick();
        vectors++; if ({hitA, livesA, scoreA} !== {1'b1, 3'd1, 16'd3}) begin miscompares++; $display("FAIL second_hit hit/lives/score=%0d/%0d/%0d exp 1/1/3", hitA, livesA, scoreA); end
    endtask

    task automatic three_hits();
        set_ch(0, 0, 20, 0); set_ch(1, 1, 10, 10); set_ch(2, 0, 20, 0); set_ch(3, 0, 20, 0);
        for (int h = 1; h <= 3; h++) begin
            do_tick();
            vectors++; if (livesA !== 3'(3 - h)) begin miscompares++; $display("FAIL hit_%0d lives=%0d exp=%0d", h, livesA, 3 - h); end
            if (h < 3) begin do_tick(); do_tick(); end
        end
    endtask

    task automatic test_game_over();
        pulse_restart();
        for (int i = 0; i < 4; i++) set_ch(i, 1, 5, 0);
        pulse_start();
        do_tick();
        for (int i = 0; i < 3; i++) set_ch(i, 1, 20, 0);
        do_tick();
        for (int i = 0; i < 3; i++) set_ch(i, 1, 5, 0);
        do_tick();
        vectors++; if (scoreA !== 16'd7) begin miscompares++; $display("FAIL score_seven score=%0d exp=7", scoreA); end
        three_hits();
        vectors++; if ({stateA, goA, hitA, highA} !== {2'd3, 1'b1, 1'b1, 16'd0}) begin miscompares++; $display("FAIL over_entry state/go/hit/high=%0d/%0d/%0d/%0d exp 3/1/1/0", stateA, goA, hitA, highA); end
        step();
        vectors++; if ({highA, hitA} !== {16'd7, 1'b0}) begin miscompares++; $display("FAIL high_settle high=%0d hit=%0d exp 7/0", highA, hitA); end
        set_ch(0, 1, 5, 0);
        start = 1'b1; do_tick(); start = 1'b0;
        vectors++; if ({scoreA, stateA, livesA} !== {16'd7, 2'd3, 3'd0}) begin miscompares++; $display("FAIL over_frozen score/state/lives=%0d/%0d/%0d exp 7/3/0", scoreA, stateA, livesA); end
    endtask

    task automatic test_restart();
        pulse_restart();
        vectors++; if ({scoreA, livesA, stateA, goA, highA} !== {16'd0, 3'd3, 2'd0, 1'b0, 16'd7}) begin miscompares++; $display("FAIL restart score/lives/state/go/high=%0d/%0d/%0d/%0d/%0d exp 0/3/0/0/7", scoreA, livesA, stateA, goA, highA); end
        for (int i = 0; i < 4; i++) set_ch(i, 1, 5, 0);
        pulse_start();
        do_tick();
        three_hits();
        step();
        vectors++; if ({highA, scoreA, stateA} !== {16'd7, 16'd4, 2'd3}) begin miscompares++; $display("FAIL high_kept high/score/state=%0d/%0d/%0d exp 7/4/3", highA, scoreA, stateA); end
    endtask

    task automatic test_saturate();
        pulse_restart();
        pulse_start();
        repeat (3) begin
            for (int i = 0; i < 4; i++) set_ch(i, 1, 5, 0);
            do_tick();
            for (int i = 0; i < 4; i++) set_ch(i, 1, 20, 0);
            do_tick();
        end
        set_ch(0, 1, 5, 0); set_ch(1, 1, 5, 0);
        do_tick();
        vectors++; if (scoreB !== 4'd14) begin miscompares++; $display("FAIL sat_pre scoreB=%0d exp=14", scoreB); end
        for (int i = 0; i < 4; i++) set_ch(i, 1, 20, 0);
        do_tick();
        set_ch(0, 1, 5, 0); set_ch(1, 1, 5, 0); set_ch(2, 1, 5, 0);
        do_tick();
        vectors++; if ({scoreB, scoreA} !== {4'd15, 16'd17}) begin miscompares++; $display("FAIL saturate scoreB=%0d scoreA=%0d exp 15/17", scoreB, scoreA); end
        for (int i = 0; i < 4; i++) set_ch(i, 1, 20, 0);
        set_ch(1, 1, 10, 10);
        do_tick();
        vectors++; if ({stateA, stateB, livesB} !== {2'd2, 2'd2, 3'd2}) begin miscompares++; $display("FAIL pre_reset_invuln stateA/stateB/livesB=%0d/%0d/%0d exp 2/2/2", stateA, stateB, livesB); end
        reset = 1'b1; step(); reset = 1'b0;
        vectors++; if ({highA, livesA, stateA, scoreA} !== {16'd0, 3'd3, 2'd0, 16'd0}) begin miscompares++; $display("FAIL reset_mid_invuln high/lives/state/score=%0d/%0d/%0d/%0d exp 0/3/0/0", highA, livesA, stateA, scoreA); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 399) == 0);
            restart = ($urandom_range(0, 59) == 0);
            start   = ($urandom_range(0, 9) == 0);
            tick    = ($urandom_range(0, 9) < 7);
            player_x = 8'($urandom_range(8, 12));
            player_y = 8'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++)
                set_ch(i, 1'($urandom_range(0, 1)), $urandom_range(6, 14), $urandom_range(0, 1));
            step();
            vectors++;
            if ({scoreA, highA, livesA, stateA, goA, hitA} !==
                {16'(mSc[0]), 16'(mHs[0]), 3'(mLv[0]), 2'(mSt[0]), mSt[0] == 3, mHit[0]}) begin
                miscompares++;
                $display("FAIL random_A cycle=%0d got s=%0d h=%0d l=%0d st=%0d go=%0d hit=%0d exp s=%0d h=%0d l=%0d st=%0d hit=%0d",
                         n, scoreA, highA, livesA, stateA, goA, hitA, mSc[0], mHs[0], mLv[0], mSt[0], mHit[0]);
            end
            vectors++;
            if ({scoreB, highB, livesB, stateB, goB, hitB} !==
                {4'(mSc[1]), 4'(mHs[1]), 3'(mLv[1]), 2'(mSt[1]), mSt[1] == 3, mHit[1]}) begin
                miscompares++;
                $display("FAIL random_B cycle=%0d got s=%0d h=%0d l=%0d st=%0d go=%0d hit=%0d exp s=%0d h=%0d l=%0d st=%0d hit=%0d",
                         n, scoreB, highB, livesB, stateB, goB, hitB, mSc[1], mHs[1], mLv[1], mSt[1], mHit[1]);
            end
        end
        reset = 1'b0; restart = 1'b0; start = 1'b0; tick = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_start_tick();
        test_pass_once();
        test_collision();
        test_game_over();
        test_restart();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/game_core_multi.md
Name: game_core_multi

Overview:
- Parametrised successor to the single-obstacle score/collision logic.
- Tracks N_OBS obstacles against one player. Adds a lives counter, a post-hit invulnerability window, per-obstacle pass-once scoring, a saturating score and a persistent high score.
- Sits between the obstacle generator / player position logic and the display/score renderer.
- Evaluates once per frame on a tick strobe.

Parameters:
- X_W, 8, width of X coordinates.
- Y_W, 8, width of Y coordinates.
- N_OBS, 4, number of obstacle channels (1..16).
- SCORE_W, 16, width of score and high_score.
- LIVES, 3, starting lives (1..7).
- INVULN_TICKS, 30, number of ticks of collision immunity after a non-fatal hit (>=1).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-high; clears everything including high_score.
- tick, in, 1, one-cycle frame strobe; all game evaluation happens only on cycles where tick=1.
- start, in, 1, IDLE -> PLAY request.
- restart, in, 1, synchronous new-game request; high_score is preserved.
- obs_x, in, N_OBS*X_W, packed obstacle X coordinates; channel i at bits [i*X_W +: X_W].
- obs_y, in, N_OBS*Y_W, packed obstacle Y coordinates; same packing.
- obs_valid, in, N_OBS, per-channel obstacle-present flag.
- player_x, in, X_W, player X coordinate.
- player_y, in, Y_W, player Y coordinate.
- score, out, SCORE_W, current score.
- high_score, out, SCORE_W, best score since reset.
- lives, out, 3, remaining lives.
- state, out, 2, game state: 0 IDLE, 1 PLAY, 2 INVULN, 3 OVER.
- game_over, out, 1, high while state==OVER.
- hit_pulse, out, 1, one-cycle pulse on every counted collision.

Behaviour:
- All outputs are registered and update on the clock edge where tick (or start/restart/reset) is sampled. Latency is 1 cycle.
- Reset values: score=0, high_score=0, lives=LIVES, state=IDLE, game_over=0, hit_pulse=0, all passed flags=0, invulnerability timer=0.
- Priority: reset > restart > start/tick logic.
- restart sets:
  - score=0, lives=LIVES, state=IDLE;
  - passed flags=0, timer=0, hit_pulse=0;
  - high_score unchanged.
- Per-channel terms, evaluated combinationally, unsigned compares:
  - coll[i] = obs_valid[i] & (obs_x[i]==player_x) & (obs_y[i]==player_y).
  - newpass[i] = obs_valid[i] & (obs_x[i]<player_x) & ~passed[i].
  - Update of passed[i] on tick, in PLAY or INVULN:
    - set when newpass[i];
    - cleared when obs_valid[i]==0 or obs_x[i]>player_x (obstacle respawned);
    - otherwise held.
  - passed flags are not updated in IDLE or OVER.
- Scoring, on tick in PLAY or INVULN:
  - score += popcount(newpass).
  - Saturates at 2^SCORE_W-1, no wrap.
- States:
  - IDLE: score and lives frozen; tick ignored. start=1 -> PLAY.
  - PLAY: on tick with any coll[i]:
    - hit_pulse=1 and lives decrements by exactly 1, however many channels collide.
    - If the new lives==0 -> OVER.
    - Otherwise -> INVULN with timer=INVULN_TICKS.
  - INVULN:
    - Collisions are ignored: no hit_pulse, no decrement. Scoring continues.
    - Each tick decrements the timer; when the timer reaches 0 on a tick -> PLAY.
    - A collision on that same tick is ignored.
  - OVER:
    - score and lives frozen; game_over=1.
    - Every cycle, high_score <= max(high_score, score), so high_score settles 1 cycle after entering OVER.
    - Leaves only via restart or reset.
- start outside IDLE is ignored. start and tick arriving together in IDLE only enter PLAY; that tick is not evaluated.
- A pass and a collision on the same tick are both applied: score increments and a life is lost, including on the fatal hit.
- hit_pulse is high for exactly one cycle per counted hit; it is 0 on all other cycles.
- Inputs sampled while tick=0 have no effect.

Test Plan:
- Directed scenarios use N_OBS=4, LIVES=3, INVULN_TICKS=2 unless noted.
- Reset, start, then pass channels 0 and 2 on one tick (obs_x=5, player_x=10). Required: score=2 after 1 cycle. Holding those positions for 5 more ticks leaves score=2 (pass-once). Moving channel 0 to obs_x=20, then back to 5, gives score=3.
- In PLAY, channels 1 and 3 collide on one tick. Required:
  - hit_pulse for 1 cycle, lives=2, state=INVULN.
  - Collision repeated on the next 2 ticks: no decrement.
  - Back in PLAY after the 2nd tick; the next collision gives lives=1.
- Three hits separated by invulnerability windows. Required: after the 3rd hit, lives=0, state=OVER, game_over=1. With score=7 and high_score=0, high_score=7 one cycle later.
- restart in OVER. Required: score=0, lives=3, state=IDLE, high_score=7. A second game ending at score 4 leaves high_score=7.
- SCORE_W=4, score=14, and 3 passes on one tick. Required: score=15 (saturates). Reset asserted mid-INVULN clears high_score=0, lives=3, state=IDLE.
